// File: rtl/pll_mc_fix.sv
// Time-multiplexed fixed-point SRF-PLL: NCH three-phase channels share one multiplier.
// Each step runs Clarke/Park error, clamped PI filter and phase accumulation per channel.
module pll_mc_fix #(
  parameter int                NCH   = 3,
  parameter int                W     = 32,
  parameter int                FRAC  = 16,
  parameter logic signed [W-1:0] KP    = 32'sh0000_4000,
  parameter logic signed [W-1:0] KI    = 32'sh0000_0100,
  parameter logic signed [W-1:0] W_NOM = 32'sh0100_0000,
  parameter logic signed [W-1:0] W_MAX = 32'sh0200_0000,
  parameter logic signed [W-1:0] W_MIN = 32'sh0000_0000,
  parameter logic signed [W-1:0] I_LIM = 32'sh0100_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_user,
  input  logic             sta,
  input  logic [NCH*W-1:0] va,
  input  logic [NCH*W-1:0] vb,
  input  logic [NCH*W-1:0] vc,
  output logic             sc_req,
  output logic [W-1:0]     sc_phase,
  input  logic             sc_ack,
  input  logic [W-1:0]     sc_sin,
  input  logic [W-1:0]     sc_cos,
  output logic [NCH*W-1:0] theta,
  output logic [NCH*W-1:0] frequence,
  output logic [NCH*W-1:0] sin,
  output logic [NCH*W-1:0] cos,
  output logic             busy,
  output logic             overrun,
  output logic             done_sig
);
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WX = W + 2;
  localparam int W2 = 2 * W;

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned r;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      if (((r | (64'd1 << b)) * (r | (64'd1 << b))) <= n) r = r | (64'd1 << b);
    end
    return r;
  endfunction

  // Rounded constants: 2*sqrt(4^FRAC/3) is taken at double resolution and halved with rounding.
  localparam logic signed [W-1:0] INV3  = W'(((64'd1 << FRAC) + 64'd1) / 64'd3);
  localparam logic signed [W-1:0] ISQ3  = W'((isqrt((64'd4 << (2 * FRAC)) / 64'd3) + 64'd1) >> 1);
  localparam logic signed [W-1:0] ONE   = W'(64'd1 << FRAC);
  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] I_NEG = -I_LIM;

  function automatic logic signed [W-1:0] sat(input logic signed [W2-1:0] x);
    if (x > W2'(SMAX)) return SMAX;
    if (x < W2'(SMIN)) return SMIN;
    return W'(x);
  endfunction

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] lo,
                                                input logic signed [W-1:0] hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DIFF, S_MUL_A, S_MUL_B, S_MUL_C, S_MUL_D,
    S_ERR, S_PI_I, S_PI_P, S_PHASE, S_SC, S_NEXT, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [KW-1:0]       r_k;
  logic signed [W-1:0] r_va, r_vb, r_vc, r_s, r_d, r_alpha, r_beta, r_ac, r_bs, r_err;
  logic signed [W-1:0] r_integ [NCH];
  logic signed [W-1:0] r_freq  [NCH];
  logic signed [W-1:0] r_sin   [NCH];
  logic signed [W-1:0] r_cos   [NCH];
  logic [W-1:0]        r_theta [NCH];
  logic [W-1:0]        r_sc_phase;
  logic                r_overrun;

  logic signed [W-1:0]  w_mul_a, w_mul_b, w_mul, w_s, w_d, w_err, w_integ, w_omega;
  logic signed [W2-1:0] w_prod;
  logic signed [WX-1:0] w_s_wide, w_d_wide, w_err_wide, w_integ_wide, w_omega_wide;
  logic [W-1:0]         w_theta;

  // Operand select for the single shared multiplier.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_MUL_A: begin w_mul_a = r_s;     w_mul_b = INV3;       end
      S_MUL_B: begin w_mul_a = r_d;     w_mul_b = ISQ3;       end
      S_MUL_C: begin w_mul_a = r_alpha; w_mul_b = r_cos[r_k]; end
      S_MUL_D: begin w_mul_a = r_beta;  w_mul_b = r_sin[r_k]; end
      S_PI_I:  begin w_mul_a = r_err;   w_mul_b = KI;         end
      S_PI_P:  begin w_mul_a = r_err;   w_mul_b = KP;         end
      default: ;
    endcase
  end

  assign w_prod       = w_mul_a * w_mul_b;
  assign w_mul        = sat(w_prod >>> FRAC);
  assign w_s_wide     = (WX'(r_va) <<< 1) - WX'(r_vb) - WX'(r_vc);
  assign w_d_wide     = WX'(r_vc) - WX'(r_vb);
  assign w_err_wide   = WX'(r_ac) - WX'(r_bs);
  assign w_integ_wide = WX'(r_integ[r_k]) + WX'(w_mul);
  assign w_omega_wide = WX'(W_NOM) + WX'(w_mul) + WX'(r_integ[r_k]);
  assign w_s          = sat(W2'(w_s_wide));
  assign w_d          = sat(W2'(w_d_wide));
  assign w_err        = sat(W2'(w_err_wide));
  assign w_integ      = clamp(sat(W2'(w_integ_wide)), I_NEG, I_LIM);
  assign w_omega      = clamp(sat(W2'(w_omega_wide)), W_MIN, W_MAX);
  assign w_theta      = r_theta[r_k] + r_freq[r_k];

  always_comb begin
    w_next   = r_state;
    sc_req   = 1'b0;
    busy     = 1'b1;
    done_sig = 1'b0;
    case (r_state)
      S_IDLE:  begin busy = 1'b0; if (sta) w_next = S_LOAD; end
      S_LOAD:  w_next = S_DIFF;
      S_DIFF:  w_next = S_MUL_A;
      S_MUL_A: w_next = S_MUL_B;
      S_MUL_B: w_next = S_MUL_C;
      S_MUL_C: w_next = S_MUL_D;
      S_MUL_D: w_next = S_ERR;
      S_ERR:   w_next = S_PI_I;
      S_PI_I:  w_next = S_PI_P;
      S_PI_P:  w_next = S_PHASE;
      S_PHASE: w_next = S_SC;
      S_SC:    begin sc_req = 1'b1; if (sc_ack) w_next = S_NEXT; end
      S_NEXT:  w_next = (r_k == KW'(NCH - 1)) ? S_DONE : S_LOAD;
      S_DONE:  begin busy = 1'b0; done_sig = 1'b1; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_overrun  <= 1'b0;
      r_sc_phase <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_theta[i] <= '0;
        r_integ[i] <= '0;
        r_freq[i]  <= W_NOM;
        r_sin[i]   <= '0;
        r_cos[i]   <= ONE;
      end
    end else begin
      // Any sta outside IDLE, including the DONE cycle, is dropped and flagged.
      if (sta && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (rst_user) begin
        r_state <= S_IDLE;
        for (int i = 0; i < NCH; i++) begin
          r_theta[i] <= '0;
          r_integ[i] <= '0;
          r_freq[i]  <= W_NOM;
          r_sin[i]   <= '0;
          r_cos[i]   <= ONE;
        end
      end else begin
        r_state <= w_next;
        case (r_state)
          S_IDLE:  if (sta) r_k <= '0;
          S_LOAD:  begin
            r_va <= va[r_k*W +: W];
            r_vb <= vb[r_k*W +: W];
            r_vc <= vc[r_k*W +: W];
          end
          S_DIFF:  begin r_s <= w_s; r_d <= w_d; end
          S_MUL_A: r_alpha <= w_mul;
          S_MUL_B: r_beta  <= w_mul;
          S_MUL_C: r_ac    <= w_mul;
          S_MUL_D: r_bs    <= w_mul;
          S_ERR:   r_err   <= w_err;
          S_PI_I:  r_integ[r_k] <= w_integ;
          S_PI_P:  r_freq[r_k]  <= w_omega;
          S_PHASE: begin r_theta[r_k] <= w_theta; r_sc_phase <= w_theta; end
          S_SC:    if (sc_ack) begin r_sin[r_k] <= sc_sin; r_cos[r_k] <= sc_cos; end
          S_NEXT:  if (r_k != KW'(NCH - 1)) r_k <= r_k + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign sc_phase = r_sc_phase;
  assign overrun  = r_overrun;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign theta[g*W +: W]     = r_theta[g];
    assign frequence[g*W +: W] = r_freq[g];
    assign sin[g*W +: W]       = r_sin[g];
    assign cos[g*W +: W]       = r_cos[g];
  end

endmodule

// File: tb/tb_pll_mc_fix.sv
// Bench for pll_mc_fix: directed and randomized steps against an arithmetic reference
// model, with a sincos responder that stalls, answers randomly and injects stray acks.
module tb_pll_mc_fix;
  localparam int     NCH   = 3;
  localparam int     W     = 32;
  localparam int     FRAC  = 16;
  localparam longint KP    = 16384;
  localparam longint KI    = 256;
  localparam longint W_NOM = 64'h0100_0000;
  localparam longint W_MAX = 64'h0200_0000;
  localparam longint W_MIN = 0;
  localparam longint I_LIM = 64'h0100_0000;
  localparam longint INV3  = 21845;   // round(65536/3)
  localparam longint ISQ3  = 37837;   // round(65536/sqrt(3))

  logic             clk = 1'b0;
  logic             rst, rst_user, sta;
  logic [NCH*W-1:0] va, vb, vc;
  logic             sc_req, sc_ack;
  logic [W-1:0]     sc_phase, sc_sin, sc_cos;
  logic [NCH*W-1:0] theta, frequence, sin_o, cos_o;
  logic             busy, overrun, done_sig;

  pll_mc_fix dut (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta),
    .va(va), .vb(vb), .vc(vc),
    .sc_req(sc_req), .sc_phase(sc_phase), .sc_ack(sc_ack), .sc_sin(sc_sin), .sc_cos(sc_cos),
    .theta(theta), .frequence(frequence), .sin(sin_o), .cos(cos_o),
    .busy(busy), .overrun(overrun), .done_sig(done_sig)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_pass = 0;
  longint v_a [NCH], v_b [NCH], v_c [NCH];
  longint m_theta [NCH], m_integ [NCH], m_freq [NCH], m_sin [NCH], m_cos [NCH];
  longint q_ph [$], q_sin [$], q_cos [$];
  int     ack_dly [NCH];
  bit     rand_sc = 1'b0;
  bit     spur = 1'b0;
  int     resp_k = 0;
  int     wcnt = 0;
  bit     req_seen = 1'b0;
  logic [W-1:0] ph_hold;
  int     lat, nd;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %08h want %08h", tag, obs, exp);
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint lim(input longint x, input longint lo, input longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat((a * b) >>> FRAC);
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    int t;
    t = int'(v);
    return longint'(t);
  endfunction

  function automatic longint rnd_v();
    if ($urandom_range(0, 1) == 1) return longint'(int'($urandom));
    return longint'($urandom_range(0, 32'h3FFFF)) - 64'sd131072;
  endfunction

  // Sincos responder: answers after ack_dly[channel] wait cycles, logs what it presented.
  always @(negedge clk) begin
    if (sc_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        ph_hold  = sc_phase;
        wcnt     = 0;
      end else begin
        check("sc_phase_hold", sc_phase, ph_hold);
      end
      if (wcnt >= ack_dly[resp_k % NCH]) begin
        sc_ack = 1'b1;
        sc_sin = rand_sc ? $urandom : 32'h0;
        sc_cos = rand_sc ? $urandom : 32'h0001_0000;
        q_ph.push_back(longint'(sc_phase));
        q_sin.push_back(longint'(sc_sin));
        q_cos.push_back(longint'(sc_cos));
        resp_k++;
      end else begin
        sc_ack = 1'b0;
        wcnt++;
      end
    end else begin
      req_seen = 1'b0;
      sc_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      sc_sin   = $urandom;
      sc_cos   = $urandom;
    end
  end

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_theta[k] = 0; m_integ[k] = 0; m_freq[k] = W_NOM; m_sin[k] = 0; m_cos[k] = 65536;
    end
    q_ph.delete(); q_sin.delete(); q_cos.delete();
  endtask

  task automatic drive_v();
    for (int k = 0; k < NCH; k++) begin
      va[k*W +: W] = W'(v_a[k]);
      vb[k*W +: W] = W'(v_b[k]);
      vc[k*W +: W] = W'(v_c[k]);
    end
  endtask

  task automatic set_all_v(input longint a, input longint b, input longint c);
    for (int k = 0; k < NCH; k++) begin v_a[k] = a; v_b[k] = b; v_c[k] = c; end
    drive_v();
  endtask

  task automatic compare_all();
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("theta%0d", k), theta[k*W +: W], W'(m_theta[k]));
      check($sformatf("freq%0d", k), frequence[k*W +: W], W'(m_freq[k]));
      check($sformatf("sin%0d", k), sin_o[k*W +: W], W'(m_sin[k]));
      check($sformatf("cos%0d", k), cos_o[k*W +: W], W'(m_cos[k]));
    end
  endtask

  // One step of the loop, per channel, from the arithmetic rules.
  task automatic model_step();
    longint s, d, al, be, err, om;
    for (int k = 0; k < NCH; k++) begin
      s   = sat(2 * v_a[k] - v_b[k] - v_c[k]);
      d   = sat(v_c[k] - v_b[k]);
      al  = fmul(s, INV3);
      be  = fmul(d, ISQ3);
      err = sat(fmul(al, m_cos[k]) - fmul(be, m_sin[k]));
      m_integ[k] = lim(sat(m_integ[k] + fmul(KI, err)), -I_LIM, I_LIM);
      om  = lim(sat(W_NOM + fmul(KP, err) + m_integ[k]), W_MIN, W_MAX);
      m_freq[k]  = om;
      m_theta[k] = (m_theta[k] + om) & 64'hFFFF_FFFF;
      if (q_ph.size() == 0) begin
        check($sformatf("sc_request%0d", k), 1'b0, 1'b1);
      end else begin
        check($sformatf("sc_phase%0d", k), W'(q_ph.pop_front()), W'(m_theta[k]));
        m_sin[k] = sx(W'(q_sin.pop_front()));
        m_cos[k] = sx(W'(q_cos.pop_front()));
      end
    end
    compare_all();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // sta in cycle 0; optional second sta in cycle 'extra', optional sta during DONE.
  task automatic run_step(input int extra, input bit sod, output int l, output int n);
    @(posedge clk); #1;
    resp_k = 0;
    sta = 1'b1;
    l = -1;
    n = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      sta = (c == extra);
      @(negedge clk);
      if (done_sig) begin
        n++;
        if (l < 0) l = c;
        if (sod) sta = 1'b1;
      end
      if (l >= 0 && c >= l + 3) break;
    end
    sta = 1'b0;
  endtask

  task automatic do_step(input int extra, input bit sod);
    int exp_lat;
    exp_lat = 12 * NCH + 1;
    for (int k = 0; k < NCH; k++) exp_lat += ack_dly[k];
    run_step(extra, sod, lat, nd);
    check("done_seen", 1'(lat >= 0), 1'b1);
    if (lat >= 0) begin
      check("latency", lat, exp_lat);
      check("done_count", nd, 1);
      check("busy_after", busy, 1'b0);
      model_step();
    end
  endtask

  initial begin
    rst = 1'b1; rst_user = 1'b0; sta = 1'b0;
    sc_ack = 1'b0; sc_sin = '0; sc_cos = '0;
    for (int k = 0; k < NCH; k++) ack_dly[k] = 0;
    set_all_v(0, 0, 0);
    do_reset();

    // Reset values
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      check("rst_theta", theta[k*W +: W], 32'h0);
      check("rst_cos", cos_o[k*W +: W], 32'h0001_0000);
      check("rst_sin", sin_o[k*W +: W], 32'h0);
      check("rst_freq", frequence[k*W +: W], 32'h0100_0000);
    end
    check("rst_done", done_sig, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_sc_req", sc_req, 1'b0);
    check("rst_sc_phase", sc_phase, 32'h0);

    // Error sign: Va=1.0, Vb=Vc=-0.5 with cos=1.0, sin=0
    set_all_v(64'sd65536, -64'sd32768, -64'sd32768);
    do_step(0, 1'b0);
    for (int k = 0; k < NCH; k++) check("err_sign_freq", frequence[k*W +: W], 32'h0100_40FE);

    // Free-run wrap with zero input
    do_reset();
    set_all_v(0, 0, 0);
    rand_sc = 1'b1;
    do_step(0, 1'b0);
    check("lat_37", lat, 37);
    for (int k = 0; k < NCH; k++) check("wrap_1", theta[k*W +: W], 32'h0100_0000);
    for (int i = 1; i < 256; i++) do_step(0, 1'b0);
    for (int k = 0; k < NCH; k++) check("wrap_256", theta[k*W +: W], 32'h0);

    // Handshake stall in channel 1
    for (int k = 0; k < NCH; k++) begin v_a[k] = rnd_v(); v_b[k] = rnd_v(); v_c[k] = rnd_v(); end
    drive_v();
    ack_dly[1] = 10;
    do_step(0, 1'b0);
    check("lat_47", lat, 47);
    ack_dly[1] = 0;

    // Clamp and integrator saturation
    do_reset();
    rand_sc = 1'b0;
    set_all_v(64'sh7FFF_0000, 0, 0);
    do_step(0, 1'b0);
    check("clamp_wmax", frequence[W-1:0], 32'h0200_0000);
    for (int i = 0; i < 7; i++) do_step(0, 1'b0);
    set_all_v(-64'sd65536, 64'sd32768, 64'sd32768);
    do_step(0, 1'b0);
    for (int k = 0; k < NCH; k++) check("integ_sat", frequence[k*W +: W], 32'h01FF_BF00);

    // rst_user during MUL_C of channel 0 aborts the step
    set_all_v(64'sh7FFF_0000, 0, 0);
    @(posedge clk); #1 sta = 1'b1;
    @(posedge clk); #1 sta = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_user = 1'b1;
    @(posedge clk); #1 rst_user = 1'b0;
    model_clear();
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_sig) nd++;
    end
    check("abort_done", nd, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_sc_req", sc_req, 1'b0);
    compare_all();
    set_all_v(0, 0, 0);
    do_step(0, 1'b0);
    for (int k = 0; k < NCH; k++) check("abort_integ", frequence[k*W +: W], 32'h0100_0000);

    // Overrun: sta while busy, survives rst_user, cleared by rst
    check("ovr_clear", overrun, 1'b0);
    do_step(5, 1'b0);
    check("ovr_busy", overrun, 1'b1);
    @(posedge clk); #1 rst_user = 1'b1;
    @(posedge clk); #1 rst_user = 1'b0;
    model_clear();
    @(negedge clk);
    check("ovr_rst_user", overrun, 1'b1);
    do_reset();
    @(negedge clk);
    check("ovr_rst", overrun, 1'b0);
    do_step(0, 1'b1);
    check("ovr_done", overrun, 1'b1);
    do_reset();

    // Randomized steps: random voltages, sincos values, ack delays, stray acks
    rand_sc = 1'b1;
    spur = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NCH; k++) begin
        v_a[k] = rnd_v(); v_b[k] = rnd_v(); v_c[k] = rnd_v();
        ack_dly[k] = $urandom_range(0, 3);
      end
      drive_v();
      do_step(0, 1'b0);
    end
    check("rand_overrun", overrun, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
